// File: rtl/correlator_bank.sv
// Multi-tap C/A code correlator: wipes off code chips, accumulates, dumps.
// Params INPUT_WIDTH/OUTPUT_WIDTH/NUM_TAPS/COUNT_WIDTH. Macro CORRELATOR_SATURATE_EN clamps sums.
// Ports: clk, reset, clear, data_available, baseband_input, ca_bits in;
//        accumulators, dump_values, dump_count, dump_valid out.
`ifndef INPUT_WIDTH
`define INPUT_WIDTH 2
`endif

module correlator_bank #(
  parameter int INPUT_WIDTH  = `INPUT_WIDTH,
  parameter int OUTPUT_WIDTH = 16,
  parameter int NUM_TAPS     = 3,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             clear,
  input  logic                             data_available,
  input  logic [INPUT_WIDTH-1:0]           baseband_input,
  input  logic [NUM_TAPS-1:0]              ca_bits,
  output logic [NUM_TAPS*OUTPUT_WIDTH-1:0] accumulators,
  output logic [NUM_TAPS*OUTPUT_WIDTH-1:0] dump_values,
  output logic [COUNT_WIDTH-1:0]           dump_count,
  output logic                             dump_valid
);

  localparam int OW = OUTPUT_WIDTH;
  typedef logic [OW-1:0] word_t;

  logic                   sign;
  logic [INPUT_WIDTH-2:0] mag;
  word_t                  pos;

  word_t conv    [NUM_TAPS];
  word_t samp_q  [NUM_TAPS];
  word_t acc_q   [NUM_TAPS];
  word_t acc_nxt [NUM_TAPS];
  word_t dump_q  [NUM_TAPS];

  logic                   valid_q;
  logic [COUNT_WIDTH-1:0] cnt_q;
  logic [COUNT_WIDTH-1:0] cnt_nxt;

  assign sign = baseband_input[INPUT_WIDTH-1];
  assign mag  = baseband_input[INPUT_WIDTH-2:0];
  // Sign-magnitude level m maps to odd value 2m+1.
  assign pos  = (word_t'(mag) << 1) | word_t'(1);

`ifdef CORRELATOR_SATURATE_EN
  function automatic word_t acc_add(
    input word_t a,
    input word_t b
  );
    logic [OW:0] s;
    s = {a[OW-1], a} + {b[OW-1], b};
    if (s[OW] != s[OW-1])
      acc_add = s[OW] ? {1'b1, {(OW-1){1'b0}}}
                      : {1'b0, {(OW-1){1'b1}}};
    else
      acc_add = s[OW-1:0];
  endfunction
`else
  function automatic word_t acc_add(
    input word_t a,
    input word_t b
  );
    acc_add = a + b;
  endfunction
`endif

  always_comb begin
    for (int k = 0; k < NUM_TAPS; k++) begin
      conv[k] = (sign ^ ~ca_bits[k]) ? pos : -pos;
    end
  end

  // A sample arriving with clear opens the new period.
  always_comb begin
    for (int k = 0; k < NUM_TAPS; k++) begin
      acc_nxt[k] = acc_q[k];
      if (clear)
        acc_nxt[k] = valid_q ? samp_q[k] : '0;
      else if (valid_q)
        acc_nxt[k] = acc_add(acc_q[k], samp_q[k]);
    end
  end

  always_comb begin
    cnt_nxt = cnt_q;
    if (clear)
      cnt_nxt = valid_q ? COUNT_WIDTH'(1) : '0;
    else if (valid_q && cnt_q != '1)
      cnt_nxt = cnt_q + COUNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 1'b0;
      cnt_q      <= '0;
      dump_count <= '0;
      dump_valid <= 1'b0;
      for (int k = 0; k < NUM_TAPS; k++) begin
        samp_q[k] <= '0;
        acc_q[k]  <= '0;
        dump_q[k] <= '0;
      end
    end else begin
      valid_q    <= data_available;
      cnt_q      <= cnt_nxt;
      dump_valid <= clear;
      if (clear)
        dump_count <= cnt_q;
      for (int k = 0; k < NUM_TAPS; k++) begin
        samp_q[k] <= conv[k];
        acc_q[k]  <= acc_nxt[k];
        if (clear)
          dump_q[k] <= acc_q[k];
      end
    end
  end

  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_pack
    assign accumulators[k*OW +: OW] = acc_q[k];
    assign dump_values[k*OW +: OW]  = dump_q[k];
  end

endmodule
